// File: rtl/cmp_iter.sv
// Iterative chunked magnitude comparator: scans operands MSB chunk first and stops
// at the first differing chunk, then produces EQ/GT/LT/NE/GE/MIN/MAX results.
module cmp_iter #(
  parameter int OPERAND_WIDTH = 8,
  parameter int CHUNK_WIDTH   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [OPERAND_WIDTH-1:0] A,
  input  logic [OPERAND_WIDTH-1:0] B,
  input  logic [2:0]               ALU_FUN,
  input  logic                     SIGNED,
  input  logic                     CMP_Enable,
  output logic                     CMP_Busy,
  output logic                     CMP_Flag,
  output logic [OPERAND_WIDTH-1:0] CMP_OUT,
  output logic [1:0]               CMP_Rel
);

  localparam int NCHUNK = OPERAND_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  localparam logic [2:0] FUN_NOP = 3'b000;
  localparam logic [2:0] FUN_EQ  = 3'b001;
  localparam logic [2:0] FUN_GT  = 3'b010;
  localparam logic [2:0] FUN_LT  = 3'b011;
  localparam logic [2:0] FUN_NE  = 3'b100;
  localparam logic [2:0] FUN_GE  = 3'b101;
  localparam logic [2:0] FUN_MIN = 3'b110;
  localparam logic [2:0] FUN_MAX = 3'b111;

  localparam logic [1:0] REL_EQ = 2'b01;
  localparam logic [1:0] REL_GT = 2'b10;
  localparam logic [1:0] REL_LT = 2'b11;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [OPERAND_WIDTH-1:0] a_reg, a_next;
  logic [OPERAND_WIDTH-1:0] b_reg, b_next;
  logic [2:0]               fun_reg, fun_next;
  logic                     sgn_reg, sgn_next;
  logic [OPERAND_WIDTH-1:0] out_reg, out_next;
  logic [1:0]               rel_reg, rel_next;
  logic                     flag_reg, flag_next;

  logic [CHUNK_WIDTH-1:0]   a_chunks [NCHUNK];
  logic [CHUNK_WIDTH-1:0]   b_chunks [NCHUNK];
  logic [CHUNK_WIDTH-1:0]   a_chunk, b_chunk;
  logic [1:0]               chunk_rel;
  logic [OPERAND_WIDTH-1:0] result;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunks[gi] = a_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign b_chunks[gi] = b_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
  end

  // Flipping the sign bit of the top chunk maps two's-complement order onto
  // unsigned order, so the same chunk comparator serves both modes.
  always_comb begin
    a_chunk = a_chunks[idx_reg];
    b_chunk = b_chunks[idx_reg];
    if (sgn_reg && (idx_reg == IDX_TOP)) begin
      a_chunk[CHUNK_WIDTH-1] = ~a_chunk[CHUNK_WIDTH-1];
      b_chunk[CHUNK_WIDTH-1] = ~b_chunk[CHUNK_WIDTH-1];
    end
  end

  always_comb begin
    if (a_chunk == b_chunk)     chunk_rel = REL_EQ;
    else if (a_chunk > b_chunk) chunk_rel = REL_GT;
    else                        chunk_rel = REL_LT;
  end

  always_comb begin
    result = '0;
    case (fun_reg)
      FUN_EQ:  result = OPERAND_WIDTH'(chunk_rel == REL_EQ);
      FUN_GT:  result = OPERAND_WIDTH'(chunk_rel == REL_GT);
      FUN_LT:  result = OPERAND_WIDTH'(chunk_rel == REL_LT);
      FUN_NE:  result = OPERAND_WIDTH'(chunk_rel != REL_EQ);
      FUN_GE:  result = OPERAND_WIDTH'(chunk_rel != REL_LT);
      FUN_MIN: result = (chunk_rel == REL_GT) ? b_reg : a_reg;
      FUN_MAX: result = (chunk_rel == REL_LT) ? b_reg : a_reg;
      default: result = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      idx_reg   <= IDX_TOP;
      a_reg     <= '0;
      b_reg     <= '0;
      fun_reg   <= FUN_NOP;
      sgn_reg   <= 1'b0;
      out_reg   <= '0;
      rel_reg   <= 2'b00;
      flag_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      fun_reg   <= fun_next;
      sgn_reg   <= sgn_next;
      out_reg   <= out_next;
      rel_reg   <= rel_next;
      flag_reg  <= flag_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    fun_next   = fun_reg;
    sgn_next   = sgn_reg;
    out_next   = out_reg;
    rel_next   = rel_reg;
    flag_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (CMP_Enable) begin
          if (ALU_FUN != FUN_NOP) begin
            a_next     = A;
            b_next     = B;
            fun_next   = ALU_FUN;
            sgn_next   = SIGNED;
            idx_next   = IDX_TOP;
            state_next = SCAN;
          end else begin
            out_next = '0;
            rel_next = 2'b00;
          end
        end
      end
      SCAN: begin
        // Early termination on the first differing chunk; the last chunk always decides.
        if ((chunk_rel != REL_EQ) || (idx_reg == '0)) begin
          rel_next   = chunk_rel;
          out_next   = result;
          flag_next  = 1'b1;
          idx_next   = IDX_TOP;
          state_next = IDLE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign CMP_Busy = (state_reg == SCAN);
  assign CMP_Flag = flag_reg;
  assign CMP_OUT  = out_reg;
  assign CMP_Rel  = rel_reg;

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter at 8-bit operands, 4-bit chunks.
module tb_cmp_iter;

  localparam int W      = 8;
  localparam int CW     = 4;
  localparam int NCHUNK = W / CW;

  logic         CLK;
  logic         RST;
  logic [W-1:0] A, B;
  logic [2:0]   ALU_FUN;
  logic         SIGNED;
  logic         CMP_Enable;
  logic         CMP_Busy;
  logic         CMP_Flag;
  logic [W-1:0] CMP_OUT;
  logic [1:0]   CMP_Rel;

  int n_checks = 0;
  int n_fail   = 0;

  cmp_iter #(.OPERAND_WIDTH(W), .CHUNK_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .SIGNED(SIGNED),
    .CMP_Enable(CMP_Enable), .CMP_Busy(CMP_Busy), .CMP_Flag(CMP_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Rel(CMP_Rel)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Presents one request and returns 1 time unit after the acceptance edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] fun, input logic sgn);
    @(negedge CLK);
    A = a; B = b; ALU_FUN = fun; SIGNED = sgn; CMP_Enable = 1'b1;
    @(posedge CLK);
    #1;
    CMP_Enable = 1'b0;
  endtask

  // Edges until CMP_Flag is seen, or -1 when the budget runs out.
  task automatic wait_flag(output int lat);
    lat = -1;
    for (int i = 1; i <= NCHUNK + 2; i++) begin
      @(posedge CLK);
      #1;
      if (CMP_Flag) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({CMP_Busy, CMP_Flag, CMP_OUT, CMP_Rel} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b flag=%b out=%h rel=%b, want 0 0 00 00",
               CMP_Busy, CMP_Flag, CMP_OUT, CMP_Rel);
    end
    $display("reset: busy=%b flag=%b out=%h rel=%b", CMP_Busy, CMP_Flag, CMP_OUT, CMP_Rel);
  endtask

  task automatic run_case(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] fun, input logic sgn, input int exp_lat,
                          input logic [W-1:0] exp_out, input logic [1:0] exp_rel);
    int lat;
    start_op(a, b, fun, sgn);
    n_checks++;
    if (CMP_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: busy=%b want 1", name, CMP_Busy);
    end
    wait_flag(lat);
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (CMP_OUT !== exp_out || CMP_Rel !== exp_rel || CMP_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_result: out=%h rel=%b busy=%b want out=%h rel=%b busy=0",
               name, CMP_OUT, CMP_Rel, CMP_Busy, exp_out, exp_rel);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (CMP_Flag !== 1'b0 || CMP_OUT !== exp_out) begin
      n_fail++;
      $display("FAIL %s_hold: flag=%b out=%h want flag=0 out=%h", name, CMP_Flag, CMP_OUT, exp_out);
    end
    $display("%s: A=%h B=%h fun=%b sgn=%b lat=%0d out=%h rel=%b", name, a, b, fun, sgn, lat, CMP_OUT, CMP_Rel);
  endtask

  task automatic test_eq;
    run_case("eq_unsigned", 8'h35, 8'h35, 3'b001, 1'b0, 2, 8'h01, 2'b01);
  endtask

  task automatic test_gt;
    run_case("gt_unsigned", 8'h80, 8'h01, 3'b010, 1'b0, 1, 8'h01, 2'b10);
    run_case("gt_signed",   8'h80, 8'h01, 3'b010, 1'b1, 1, 8'h00, 2'b11);
  endtask

  task automatic test_minmax;
    run_case("min_signed",   8'hF0, 8'h05, 3'b110, 1'b1, 1, 8'hF0, 2'b11);
    run_case("max_signed",   8'hF0, 8'h05, 3'b111, 1'b1, 1, 8'h05, 2'b11);
    run_case("min_unsigned", 8'hF0, 8'h05, 3'b110, 1'b0, 1, 8'h05, 2'b10);
    run_case("max_tie",      8'h5A, 8'h5A, 3'b111, 1'b0, 2, 8'h5A, 2'b01);
  endtask

  task automatic test_ne_ge;
    run_case("ne_equal",  8'h35, 8'h35, 3'b100, 1'b0, 2, 8'h00, 2'b01);
    run_case("ge_signed", 8'h7F, 8'h80, 3'b101, 1'b1, 1, 8'h01, 2'b10);
    run_case("lt_lowchk", 8'h47, 8'h42, 3'b011, 1'b0, 2, 8'h00, 2'b10);
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge CLK);
    A = 8'h12; B = 8'h13; ALU_FUN = 3'b011; SIGNED = 1'b0; CMP_Enable = 1'b1;
    @(posedge CLK);
    #1;
    A = 8'hFF; B = 8'h00; ALU_FUN = 3'b010;
    @(posedge CLK);
    #1;
    n_checks++;
    if (CMP_Flag !== 1'b0 || CMP_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ignore: flag=%b busy=%b want flag=0 busy=1", CMP_Flag, CMP_Busy);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (CMP_Flag !== 1'b1 || CMP_OUT !== 8'h01 || CMP_Rel !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_first: flag=%b out=%h rel=%b want flag=1 out=01 rel=11",
               CMP_Flag, CMP_OUT, CMP_Rel);
    end
    $display("b2b first: out=%h rel=%b", CMP_OUT, CMP_Rel);
    @(posedge CLK);
    #1;
    CMP_Enable = 1'b0;
    n_checks++;
    if (CMP_Flag !== 1'b0 || CMP_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: flag=%b busy=%b want flag=0 busy=1", CMP_Flag, CMP_Busy);
    end
    wait_flag(lat);
    n_checks++;
    if (lat != 1 || CMP_OUT !== 8'h01 || CMP_Rel !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d out=%h rel=%b want lat=1 out=01 rel=10",
               lat, CMP_OUT, CMP_Rel);
    end
    $display("b2b second: lat=%0d out=%h rel=%b", lat, CMP_OUT, CMP_Rel);
  endtask

  task automatic test_reset_mid_scan;
    bit flag_seen;
    start_op(8'h11, 8'h12, 3'b011, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    n_checks++;
    if (CMP_Busy !== 1'b0 || CMP_Flag !== 1'b0 || CMP_OUT !== 8'h00 || CMP_Rel !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b flag=%b out=%h rel=%b want 0 0 00 00",
               CMP_Busy, CMP_Flag, CMP_OUT, CMP_Rel);
    end
    @(negedge CLK);
    RST = 1'b1;
    flag_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      if (CMP_Flag || CMP_Busy) flag_seen = 1'b1;
    end
    n_checks++;
    if (flag_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: activity seen after release, want none");
    end
    $display("reset mid-scan: busy=%b flag=%b out=%h", CMP_Busy, CMP_Flag, CMP_OUT);
  endtask

  task automatic test_nop_clear;
    run_case("eq_before_nop", 8'h35, 8'h35, 3'b001, 1'b0, 2, 8'h01, 2'b01);
    @(negedge CLK);
    ALU_FUN = 3'b000; CMP_Enable = 1'b1;
    @(posedge CLK);
    #1;
    CMP_Enable = 1'b0;
    n_checks++;
    if (CMP_OUT !== 8'h00 || CMP_Rel !== 2'b00 || CMP_Flag !== 1'b0 || CMP_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_clear: out=%h rel=%b flag=%b busy=%b want 00 00 0 0",
               CMP_OUT, CMP_Rel, CMP_Flag, CMP_Busy);
    end
    $display("nop: out=%h rel=%b flag=%b busy=%b", CMP_OUT, CMP_Rel, CMP_Flag, CMP_Busy);
  endtask

  initial begin
    RST = 1'b0; A = '0; B = '0; ALU_FUN = 3'b000; SIGNED = 1'b0; CMP_Enable = 1'b0;
    #23;
    test_reset;
    @(negedge CLK);
    RST = 1'b1;
    test_eq;
    test_gt;
    test_minmax;
    test_ne_ge;
    test_back_to_back;
    test_reset_mid_scan;
    test_nop_clear;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
